alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, handshaked successor to the 8-bit combinational ALU. Adds configurable width, an extended opcode set, status flags, registered output and an optional iterative multiplier. Sits between an operand source (decoder/sequencer) and a result consumer, with valid/ready flow control on both sides.

## Interface
- `WIDTH`, default 8: operand/result width. Legal range 4..64.
- `clk`  in  1  the single clock.
- `rst_n`  in  1  reset. One clock; reset is synchronous and active-low.
- `in_valid`  in  1  operands and opcode valid.
- `in_ready`  out  1  block can accept an operation.
- `op`  in  4  opcode (see Operation).
- `a`, `b`  in  WIDTH  operands.
- `out_valid`  out  1  result and flags valid.
- `out_ready`  in  1  consumer accepts result.
- `result`  out  WIDTH  result; low half of the product for MUL.
- `result_hi`  out  WIDTH  high half of the product for MUL; 0 for every other op.
- `flags`  out  4  {carry, overflow, negative, zero}.
- `err`  out  1  illegal or disabled opcode.

## Operation
- Opcodes 0–7 keep the legacy encoding:
  - 0 ADD, 1 SUB, 2 SLL, 3 SRL, 4 AND, 5 OR, 6 XOR, 7 EQL.
- New opcodes:
  - 8 SRA.
  - 9 SLT (signed less-than).
  - 10 SLTU (unsigned less-than).
  - 11 MUL (unsigned WIDTH×WIDTH→2·WIDTH).
- Opcodes 12–15 are illegal: result 0, result_hi 0, flags 0, err=1. They still complete with normal single-op latency.
- Shifts use all of `b`, treated as unsigned:
  - `b` ≥ WIDTH gives SLL/SRL = 0.
  - `b` ≥ WIDTH gives SRA = all bits equal to `a[WIDTH-1]`.
- EQL, SLT and SLTU return 0 or 1 in bit 0; upper bits are 0.
- carry:
  - ADD: carry-out.
  - SUB: borrow, i.e. a<b unsigned.
  - All other ops: 0.
- overflow: signed overflow for ADD and SUB; 0 otherwise.
- zero = (result==0). For MUL, zero = full product == 0.
- negative = result[WIDTH-1]. For MUL, negative = result_hi[WIDTH-1].
- FSM states:
  - IDLE: accepts operations. A non-MUL accept latches the outputs and stays in IDLE.
  - MUL_RUN: iterative shift-add multiply, one multiplier bit per cycle, WIDTH cycles. Moves to IDLE with outputs loaded.
- Output register:
  - Holds result, result_hi, flags and err stable while out_valid=1 and out_ready=0.
  - Clears out_valid on a handshake with no new result loading in the same cycle.
- `in_ready` = (state==IDLE) && (!out_valid || out_ready). This is a combinational path from out_ready; it is permitted and documented.
- Reset (any state, including mid-MUL):
  - State goes to IDLE and any in-flight multiply is dropped.
  - out_valid=0; result, result_hi, flags and err all 0.
  - in_ready is 1 in the cycle after reset deasserts.

## Timing
- Accept occurs at a rising edge where in_valid && in_ready.
- Non-MUL: out_valid=1 from the next cycle (latency 1). Throughput is 1 op/cycle while out_ready is held at 1.
- MUL: out_valid=1 exactly WIDTH+1 cycles after the accept edge. in_ready=0 for those WIDTH cycles.
- Output stall: results do not advance while out_valid=1 and out_ready=0, and no new op is accepted.
- Simultaneous result handshake and new accept: the old result retires and the new result loads on the same edge, so out_valid stays 1.
- Inputs are sampled only at accept; a, b and op may change freely afterwards.

## Configuration
- Macro: `ALU_SEQ_MUL_EN`.
- Defined: MUL is implemented as above.
- Undefined:
  - MUL is treated as an illegal opcode (err=1, latency 1).
  - No MUL_RUN state and no multiplier datapath are present.

## Structure
- Package `alu_seq_pkg` holds:
  - the opcode localparams/enum;
  - FSM state enum;
  - flag bit indices (CARRY=3, OVF=2, NEG=1, ZERO=0).
- Sub-module `alu_mul_iter` (shift-add multiplier):
  - Interface: start, a, b → done, product[2·WIDTH-1:0].
  - Instantiated only under `ALU_SEQ_MUL_EN`.
  - Carries its own synchronous active-low reset.

## Test plan
- WIDTH=8, ADD a=0xFF b=0x01, out_ready=1 → next cycle result=0x00, carry=1, zero=1, overflow=0, err=0.
- SUB a=0x80 b=0x01 → result=0x7F, overflow=1, carry=0. SLT a=0x80 b=0x01 → 1. SLTU a=0x80 b=0x01 → 0.
- Shifts with a=0x90: SRA b=9 → 0xFF. SRL b=9 → 0x00. SLL b=3 → 0x80.
- MUL a=0xFF b=0xFF (macro defined) → in_ready=0 for 8 cycles; at accept+9 result=0x01, result_hi=0xFE, negative=1.
- Back-to-back ADDs with out_ready toggled 1,0,0,1 → no result lost or duplicated; outputs stable while stalled. Opcode 13 → err=1, result=0.
- Assert rst_n=0 during the 4th MUL_RUN cycle → next cycle out_valid=0, all outputs 0, state IDLE; no stale result appears after reset release.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM states and flag layout for alu_seq.
// The MUL_RUN state exists only when ALU_SEQ_MUL_EN is defined.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_SLL  = 4'd2,
    OP_SRL  = 4'd3,
    OP_AND  = 4'd4,
    OP_OR   = 4'd5,
    OP_XOR  = 4'd6,
    OP_EQL  = 4'd7,
    OP_SRA  = 4'd8,
    OP_SLT  = 4'd9,
    OP_SLTU = 4'd10,
    OP_MUL  = 4'd11
  } op_e;

`ifdef ALU_SEQ_MUL_EN
  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MUL_RUN = 1'b1
  } state_e;
`else
  typedef enum logic {
    ST_IDLE = 1'b0
  } state_e;
`endif

  localparam int FLAG_CARRY = 3;
  localparam int FLAG_OVF   = 2;
  localparam int FLAG_NEG   = 1;
  localparam int FLAG_ZERO  = 0;

  function automatic logic [3:0] pack_flags(input logic c, input logic v,
                                            input logic n, input logic z);
    logic [3:0] f;
    f             = '0;
    f[FLAG_CARRY] = c;
    f[FLAG_OVF]   = v;
    f[FLAG_NEG]   = n;
    f[FLAG_ZERO]  = z;
    return f;
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, WIDTH bits total.
// The first bit is consumed on the start edge, so done pulses WIDTH-1 edges later.
module alu_mul_iter
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);
  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [2*WIDTH-1:0] prod_d;
  logic [CW-1:0]      cnt_q;
  logic               busy_q;
  logic               done_q;

  // Upper half accumulates the multiplicand, then the whole register shifts right.
  function automatic logic [2*WIDTH-1:0] shift_add(input logic [2*WIDTH-1:0] p,
                                                   input logic [WIDTH-1:0]   m);
    logic [WIDTH:0] sum;
    sum = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m} : '0);
    return {sum, p[WIDTH-1:1]};
  endfunction

  always_comb begin
    prod_d = shift_add(prod_q, mcand_q);
    if (start) begin
      prod_d = shift_add({{WIDTH{1'b0}}, b}, a);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        busy_q <= 1'b1;
        cnt_q  <= CW'(WIDTH - 1);
      end else if (busy_q) begin
        cnt_q <= cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      mcand_q <= a;
      prod_q  <= prod_d;
    end else if (busy_q) begin
      prod_q <= prod_d;
    end
  end

  assign done    = done_q;
  assign product = prod_q;

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU with registered result/flags; MUL uses an iterative multiplier
// when ALU_SEQ_MUL_EN is defined, otherwise opcode 11 reports err like 12..15.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [3:0]       flags,
  output logic             err
);
  state_e                  state_q;
  logic                    out_valid_q;
  logic [WIDTH-1:0]        result_q;
  logic [WIDTH-1:0]        result_hi_q;
  logic [3:0]              flags_q;
  logic                    err_q;
  logic                    accept;

  logic [WIDTH-1:0]        res_d;
  logic [3:0]              flags_d;
  logic                    err_d;
  logic                    carry_d;
  logic                    ovf_d;
  logic [WIDTH:0]          sum_w;
  logic [WIDTH:0]          diff_w;
  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s;
  logic signed [WIDTH-1:0] sra_w;
  logic                    shift_oob;

  // in_ready looks straight through to out_ready so a retiring result frees the slot.
  assign in_ready = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  assign a_s       = $signed(a);
  assign b_s       = $signed(b);
  assign sum_w     = {1'b0, a} + {1'b0, b};
  assign diff_w    = {1'b0, a} - {1'b0, b};
  assign sra_w     = a_s >>> b;
  assign shift_oob = (65'(b) >= 65'(WIDTH));

  always_comb begin
    res_d   = '0;
    carry_d = 1'b0;
    ovf_d   = 1'b0;
    err_d   = 1'b0;
    case (op)
      OP_ADD: begin
        res_d   = sum_w[WIDTH-1:0];
        carry_d = sum_w[WIDTH];
        ovf_d   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_w[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        res_d   = diff_w[WIDTH-1:0];
        carry_d = diff_w[WIDTH];
        ovf_d   = (a[WIDTH-1] != b[WIDTH-1]) && (diff_w[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLL:  res_d = shift_oob ? '0 : (a << b);
      OP_SRL:  res_d = shift_oob ? '0 : (a >> b);
      OP_AND:  res_d = a & b;
      OP_OR:   res_d = a | b;
      OP_XOR:  res_d = a ^ b;
      OP_EQL:  res_d[0] = (a == b);
      OP_SRA:  res_d = shift_oob ? {WIDTH{a[WIDTH-1]}} : sra_w;
      OP_SLT:  res_d[0] = (a_s < b_s);
      OP_SLTU: res_d[0] = (a < b);
      default: err_d = 1'b1;
    endcase
    flags_d = err_d ? 4'b0000 : pack_flags(carry_d, ovf_d, res_d[WIDTH-1], ~|res_d);
  end

`ifdef ALU_SEQ_MUL_EN
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;

  assign mul_start = accept && (op == OP_MUL);

  alu_mul_iter #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (mul_start),
    .a      (a),
    .b      (b),
    .done   (mul_done),
    .product(mul_prod)
  );
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      result_hi_q <= '0;
      flags_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
`ifdef ALU_SEQ_MUL_EN
            if (op == OP_MUL) begin
              state_q     <= ST_MUL_RUN;
              out_valid_q <= 1'b0;
            end else
`endif
            begin
              result_q    <= res_d;
              result_hi_q <= '0;
              flags_q     <= flags_d;
              err_q       <= err_d;
              out_valid_q <= 1'b1;
            end
          end else if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
`ifdef ALU_SEQ_MUL_EN
        ST_MUL_RUN: begin
          if (mul_done) begin
            result_q    <= mul_prod[WIDTH-1:0];
            result_hi_q <= mul_prod[2*WIDTH-1:WIDTH];
            flags_q     <= pack_flags(1'b0, 1'b0, mul_prod[2*WIDTH-1], ~|mul_prod);
            err_q       <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
`endif
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign flags     = flags_q;
  assign err       = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=8): directed ops push expectations,
// a negedge monitor pops and compares on every presented result.
module tb_alu_seq;
  import alu_seq_pkg::*;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic [3:0]   fl;
    logic         er;
    int           due;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic [W-1:0] result_hi;
  logic [3:0]   flags;
  logic         err;

  int           n_checks = 0;
  int           n_errors = 0;
  int           cyc = 0;
  logic [31:0]  rdy_seq = '0;
  int           rdy_len = 0;

  exp_t         sb[$];
  exp_t         cur;
  logic         new_item = 1'b1;
  logic         stalled = 1'b0;
  logic [W-1:0] hold_res;
  logic [W-1:0] hold_hi;
  logic [3:0]   hold_fl;
  logic         hold_err;

  alu_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .result_hi(result_hi),
    .flags    (flags),
    .err      (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (rdy_len > 0) begin
      out_ready = rdy_seq[0];
      rdy_seq   = rdy_seq >> 1;
      rdy_len   = rdy_len - 1;
    end else begin
      out_ready = 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, actual running, required finished");
    $fatal(1, "watchdog");
  end

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endfunction

  // Called at posedge+1; returns at posedge+1 just after the accept edge.
  task automatic issue(input logic [3:0] o, input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic [W-1:0] er, input logic [W-1:0] eh, input logic [3:0] ef,
                       input logic ee, input int lat);
    exp_t e;
    int   n;
    n        = 0;
    op       = o;
    a        = ia;
    b        = ib;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", 64'(in_ready), 64'(1));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      return;
    end
    e.res = er;
    e.hi  = eh;
    e.fl  = ef;
    e.er  = ee;
    e.due = cyc + 1 + lat;
    sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op       = 4'($urandom);
    a        = W'($urandom);
    b        = W'($urandom);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      new_item = 1'b1;
      stalled  = 1'b0;
    end else begin
      if (stalled) check("stall_valid_held", 64'(out_valid), 64'(1));
      if (out_valid) begin
        if (new_item) begin
          check("output_expected", 64'(sb.size() != 0), 64'(1));
          if (sb.size() != 0) begin
            cur = sb[0];
            check("latency_cycle", 64'(cyc), 64'(cur.due));
            check("result", 64'(result), 64'(cur.res));
            check("result_hi", 64'(result_hi), 64'(cur.hi));
            check("flags", 64'(flags), 64'(cur.fl));
            check("err", 64'(err), 64'(cur.er));
          end
        end else begin
          check("stall_result", 64'(result), 64'(hold_res));
          check("stall_result_hi", 64'(result_hi), 64'(hold_hi));
          check("stall_flags", 64'(flags), 64'(hold_fl));
          check("stall_err", 64'(err), 64'(hold_err));
        end
        if (out_ready && sb.size() != 0) void'(sb.pop_front());
      end
      new_item = !out_valid || out_ready;
      stalled  = out_valid && !out_ready;
      hold_res = result;
      hold_hi  = result_hi;
      hold_fl  = flags;
      hold_err = err;
    end
  end

  initial begin
    int stale;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    op       = '0;
    a        = '0;
    b        = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", 64'(out_valid), 64'(0));
    check("reset_result", 64'(result), 64'(0));
    check("reset_result_hi", 64'(result_hi), 64'(0));
    check("reset_flags", 64'(flags), 64'(0));
    check("reset_err", 64'(err), 64'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_init", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;

    // Flags are {carry, overflow, negative, zero}.
    issue(OP_ADD,  8'hFF, 8'h01, 8'h00, 8'h00, 4'b1001, 1'b0, 0);
    issue(OP_SUB,  8'h80, 8'h01, 8'h7F, 8'h00, 4'b0100, 1'b0, 0);
    issue(OP_SLT,  8'h80, 8'h01, 8'h01, 8'h00, 4'b0000, 1'b0, 0);
    issue(OP_SLTU, 8'h80, 8'h01, 8'h00, 8'h00, 4'b0001, 1'b0, 0);
    issue(OP_SRA,  8'h90, 8'h09, 8'hFF, 8'h00, 4'b0010, 1'b0, 0);
    issue(OP_SRL,  8'h90, 8'h09, 8'h00, 8'h00, 4'b0001, 1'b0, 0);
    issue(OP_SLL,  8'h90, 8'h03, 8'h80, 8'h00, 4'b0010, 1'b0, 0);
    issue(OP_SRA,  8'h90, 8'h02, 8'hE4, 8'h00, 4'b0010, 1'b0, 0);
    issue(OP_SRL,  8'h90, 8'h04, 8'h09, 8'h00, 4'b0000, 1'b0, 0);
    issue(OP_SLL,  8'h90, 8'h08, 8'h00, 8'h00, 4'b0001, 1'b0, 0);
    issue(OP_SRL,  8'h90, 8'hFF, 8'h00, 8'h00, 4'b0001, 1'b0, 0);
    issue(OP_AND,  8'hF0, 8'h3C, 8'h30, 8'h00, 4'b0000, 1'b0, 0);
    issue(OP_OR,   8'hF0, 8'h0F, 8'hFF, 8'h00, 4'b0010, 1'b0, 0);
    issue(OP_XOR,  8'hAA, 8'hAA, 8'h00, 8'h00, 4'b0001, 1'b0, 0);
    issue(OP_EQL,  8'h05, 8'h05, 8'h01, 8'h00, 4'b0000, 1'b0, 0);
    issue(OP_EQL,  8'h05, 8'h06, 8'h00, 8'h00, 4'b0001, 1'b0, 0);
    issue(OP_ADD,  8'h7F, 8'h01, 8'h80, 8'h00, 4'b0110, 1'b0, 0);
    issue(OP_SUB,  8'h01, 8'h02, 8'hFF, 8'h00, 4'b1010, 1'b0, 0);
    issue(4'd13,   8'h05, 8'h03, 8'h00, 8'h00, 4'b0000, 1'b1, 0);
    issue(4'd12,   8'hFF, 8'hFF, 8'h00, 8'h00, 4'b0000, 1'b1, 0);

`ifdef ALU_SEQ_MUL_EN
    issue(OP_MUL, 8'hFF, 8'hFF, 8'h01, 8'hFE, 4'b0010, 1'b0, W);
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      check("mul_busy_in_ready", 64'(in_ready), 64'(0));
    end
    @(negedge clk);
    check("mul_done_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;
    issue(OP_MUL, 8'h10, 8'h10, 8'h00, 8'h01, 4'b0000, 1'b0, W);
    issue(OP_MUL, 8'h00, 8'h37, 8'h00, 8'h00, 4'b0001, 1'b0, W);
`else
    issue(OP_MUL, 8'hFF, 8'hFF, 8'h00, 8'h00, 4'b0000, 1'b1, 0);
`endif

    // out_ready per cycle, LSB first: 1,0,0,1,0,1,1.
    @(negedge clk);
    rdy_seq = 32'h69;
    rdy_len = 7;
    @(posedge clk);
    #1;
    issue(OP_ADD, 8'h01, 8'h02, 8'h03, 8'h00, 4'b0000, 1'b0, 0);
    issue(OP_ADD, 8'h10, 8'h20, 8'h30, 8'h00, 4'b0000, 1'b0, 0);
    issue(OP_ADD, 8'h40, 8'h40, 8'h80, 8'h00, 4'b0110, 1'b0, 0);
    issue(OP_ADD, 8'h80, 8'h80, 8'h00, 8'h00, 4'b1101, 1'b0, 0);
    repeat (3) @(posedge clk);
    #1;

`ifdef ALU_SEQ_MUL_EN
    issue(OP_MUL, 8'h12, 8'h34, 8'hA8, 8'h03, 4'b0000, 1'b0, W);
`else
    @(negedge clk);
    rdy_seq = '0;
    rdy_len = 30;
    @(posedge clk);
    #1;
    issue(OP_ADD, 8'h01, 8'h01, 8'h02, 8'h00, 4'b0000, 1'b0, 0);
`endif
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrun_reset_out_valid", 64'(out_valid), 64'(0));
    check("midrun_reset_result", 64'(result), 64'(0));
    check("midrun_reset_result_hi", 64'(result_hi), 64'(0));
    check("midrun_reset_flags", 64'(flags), 64'(0));
    check("midrun_reset_err", 64'(err), 64'(0));
    sb.delete();
    #1;
    rdy_len = 0;
    rst_n   = 1'b1;
    @(negedge clk);
    check("in_ready_after_reset", 64'(in_ready), 64'(1));
    stale = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("no_stale_result", 64'(stale), 64'(0));
    @(posedge clk);
    #1;
    issue(OP_ADD, 8'h02, 8'h03, 8'h05, 8'h00, 4'b0000, 1'b0, 0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'(0));
    check("idle_out_valid", 64'(out_valid), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
